add_arb: RTL and testbench

- Two-requester arbiter and scheduler in front of the LANES-wide 32-bit lane adder, which has a 1-cycle registered latency.
- Each requester offers operand vectors over a valid/ready handshake. The block grants the shared adder round-robin, tracks which requester owns each in-flight result, and returns results through a per-requester result FIFO with its own valid/ready handshake.
- Sits between the two streaming operand producers and the single vector-add datapath.

---
 rtl/add_arb_pkg.sv | 9 +
 rtl/add_arb_adder.sv | 20 ++
 rtl/add_arb_fifo.sv | 46 ++++
 rtl/add_arb.sv | 107 ++++++++++
 tb/tb_add_arb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared widths and the in-flight result tag for the add_arb scheduler.
package add_arb_pkg;
  localparam int LANE_W = 32;
  localparam int NREQ = 2;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/add_arb_adder.sv
// add_arb_adder: LANES-wide 32-bit lane adder with one registered stage; carries are dropped.
module add_arb_adder import add_arb_pkg::*; #(
  parameter int LANES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [LANE_W*LANES-1:0] a_i,
  input  logic [LANE_W*LANES-1:0] b_i,
  output logic [LANE_W*LANES-1:0] y_o
);
  logic [LANE_W*LANES-1:0] y_q, y_d;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign y_d[l*LANE_W +: LANE_W] = a_i[l*LANE_W +: LANE_W] + b_i[l*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) y_q <= '0;
    else y_q <= y_d;
  end
  assign y_o = y_q;
endmodule

// File: rtl/add_arb_fifo.sv
// add_arb_fifo: DEPTH x W synchronous result FIFO; head reads as zero when empty.
module add_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [OW-1:0] occ_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic pop;
  assign pop = pop_i && !empty_o;
  assign empty_o = occ_q == '0;
  assign full_o = occ_q == OW'(DEPTH);
  assign occ_o = occ_q;
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  always_comb begin
    wr_d = !push_i ? wr_q : wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d = !pop ? rd_q : rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    occ_d = occ_q + OW'(push_i) - OW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin two-requester front end for the lane adder with per-requester result FIFOs.
// Optional counters stat_grant0/1 and stat_stall are built when ADD_ARB_STATS_EN is defined.
module add_arb import add_arb_pkg::*; #(
  parameter int LANES = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [LANE_W*LANES-1:0] in0_a,
  input  logic [LANE_W*LANES-1:0] in0_b,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [LANE_W*LANES-1:0] in1_a,
  input  logic [LANE_W*LANES-1:0] in1_b,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic [LANE_W*LANES-1:0] out0_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic [LANE_W*LANES-1:0] out1_data
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [31:0]             stat_grant0,
  output logic [31:0]             stat_grant1,
  output logic [31:0]             stat_stall
`endif
);
  localparam int W = LANE_W * LANES;
  localparam int OW = $clog2(DEPTH + 1);
  logic [NREQ-1:0] valid, rdy, credit, elig, gnt, push, pop, empty, full;
  logic [W-1:0] dout [NREQ];
  logic [OW-1:0] occ [NREQ];
  logic [W-1:0] sum;
  tag_t tag_q, tag_d;
  logic last_q, last_d;
  assign valid = {in1_valid, in0_valid};
  assign rdy = {out1_ready, out0_ready};
  // Credit counts the in-flight result but ignores a same-cycle pop, so a push can never overflow.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      credit[i] = int'(occ[i]) + int'(tag_q.valid && tag_q.id == 1'(i)) < DEPTH;
      push[i] = tag_q.valid && tag_q.id == 1'(i);
      pop[i] = !empty[i] && rdy[i];
    end
    elig = valid & credit;
    gnt = reset ? '0 : &elig ? (last_q ? 2'b01 : 2'b10) : elig;
    tag_d = '{valid: |gnt, id: gnt[1]};
    last_d = |gnt ? gnt[1] : last_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= '0;
      last_q <= 1'b1;
    end else begin
      tag_q <= tag_d;
      last_q <= last_d;
    end
  end
  add_arb_adder #(.LANES(LANES)) u_adder (
    .clk_i(clock),
    .rst_i(reset),
    .a_i  (gnt[1] ? in1_a : in0_a),
    .b_i  (gnt[1] ? in1_b : in0_b),
    .y_o  (sum)
  );
  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    add_arb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk_i  (clock),
      .rst_i  (reset),
      .push_i (push[g]),
      .pop_i  (pop[g]),
      .data_i (sum),
      .data_o (dout[g]),
      .occ_o  (occ[g]),
      .empty_o(empty[g]),
      .full_o (full[g])
    );
  end
  always_ff @(posedge clock) begin
    if (!reset) assert (!(|(push & full)));
  end
  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];
  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data = dout[0];
  assign out1_data = dout[1];
`ifdef ADD_ARB_STATS_EN
  logic [31:0] sg0_q, sg1_q, stall_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      sg0_q <= '0;
      sg1_q <= '0;
      stall_q <= '0;
    end else begin
      sg0_q <= sg0_q + 32'(gnt[0]);
      sg1_q <= sg1_q + 32'(gnt[1]);
      stall_q <= stall_q + 32'(|(valid & ~gnt));
    end
  end
  assign stat_grant0 = sg0_q;
  assign stat_grant1 = sg1_q;
  assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: directed self-checking bench for add_arb with LANES=2, DEPTH=4.
module tb_add_arb;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic in0_valid, in0_ready, in1_valid, in1_ready;
  logic [63:0] in0_a, in0_b, in1_a, in1_b;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  logic [63:0] out0_data, out1_data;
`ifdef ADD_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_stall;
`endif
  add_arb #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef ADD_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
`endif
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_err = 0;
  logic [63:0] q0 [$], q1 [$];
  int k0, k1, rem0, rem1, n0, n1, d0, d1;
  logic [31:0] bh0, bl0, bh1, bl1;
  logic g0, g1, o0, o1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  function automatic logic [63:0] exp_sum(input int k, input logic [31:0] bh, input logic [31:0] bl);
    return {32'(k) + bh, 32'(k) + bl};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    q0.delete();
    q1.delete();
    k0 = 0; k1 = 0; rem0 = 0; rem1 = 0;
    n0 = 0; n1 = 0; d0 = 0; d1 = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic cycle();
    in0_valid = rem0 > 0;
    in1_valid = rem1 > 0;
    in0_a = {32'(k0), 32'(k0)};
    in0_b = {bh0, bl0};
    in1_a = {32'(k1), 32'(k1)};
    in1_b = {bh1, bl1};
    #1;
    g0 = in0_ready; g1 = in1_ready; o0 = out0_valid; o1 = out1_valid;
    if (o0 && out0_ready) begin
      chk("out0_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin chk("out0_data", out0_data, q0.pop_front()); d0++; end
    end
    if (o1 && out1_ready) begin
      chk("out1_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin chk("out1_data", out1_data, q1.pop_front()); d1++; end
    end
    if (in0_valid && g0) begin q0.push_back(exp_sum(k0, bh0, bl0)); k0++; rem0--; n0++; end
    if (in1_valid && g1) begin q1.push_back(exp_sum(k1, bh1, bl1)); k1++; rem1--; n1++; end
    @(posedge clock);
    #1;
  endtask
  initial begin
    in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
    bh0 = '0; bl0 = '0; bh1 = '0; bl1 = '0;
    // reset state with requesters already asserting valid
    reset = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("rst_in0_ready", 64'(in0_ready), 64'd0);
    chk("rst_in1_ready", 64'(in1_ready), 64'd0);
    chk("rst_out0_valid", 64'(out0_valid), 64'd0);
    chk("rst_out1_valid", 64'(out1_valid), 64'd0);
    chk("rst_out0_data", out0_data, 64'd0);
    chk("rst_out1_data", out1_data, 64'd0);
    // single transfer with lane wrap
    do_reset();
    in0_valid = 1'b1; in0_a = {32'd5, 32'hFFFF_FFFF}; in0_b = {32'd7, 32'd1};
    #1;
    chk("t1_ready", 64'(in0_ready), 64'd1);
    tick();
    in0_valid = 1'b0;
    #1;
    chk("t1_lat1", 64'(out0_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out0_valid), 64'd1);
    chk("t1_data", out0_data, {32'd12, 32'd0});
    chk("t1_out1", 64'(out1_valid), 64'd0);
    tick();
    chk("t1_popped", 64'(out0_valid), 64'd0);
    // contention: strict alternation starting with requester 0
    do_reset();
    bh0 = 1000; bl0 = 2000; bh1 = 3000; bl1 = 4000;
    rem0 = 1000; rem1 = 1000;
    for (int j = 0; j < 20; j++) begin
      cycle();
      chk("cont_g0", 64'(g0), 64'(j % 2 == 0));
      chk("cont_g1", 64'(g1), 64'(j % 2 == 1));
    end
`ifdef ADD_ARB_STATS_EN
    chk("stat_grant0", 64'(stat_grant0), 64'd10);
    chk("stat_grant1", 64'(stat_grant1), 64'd10);
    chk("stat_stall", 64'(stat_stall), 64'd20);
`endif
    rem0 = 0; rem1 = 0;
    for (int j = 0; j < 4; j++) cycle();
    chk("cont_d0", 64'(d0), 64'd10);
    chk("cont_d1", 64'(d1), 64'd10);
    // backpressure on requester 0
    do_reset();
    out0_ready = 1'b0;
    bh0 = 7; bl0 = 9; bh1 = 11; bl1 = 13;
    rem0 = 10; rem1 = 1000;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (j >= 8) begin
        chk("bp_g0", 64'(g0), 64'd0);
        chk("bp_g1", 64'(g1), 64'd1);
      end
    end
    chk("bp_n0", 64'(n0), 64'd4);
    rem1 = 0;
    out0_ready = 1'b1;
    for (int j = 0; j < 40 && (d0 < 10 || q1.size() != 0); j++) cycle();
    chk("bp_d0", 64'(d0), 64'd10);
    chk("bp_q1_empty", 64'(q1.size()), 64'd0);
    // full throughput from requester 0 alone
    do_reset();
    bh0 = 100; bl0 = 100;
    rem0 = 8;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (j < 8) chk("ft_ready", 64'(g0), 64'd1);
      chk("ft_valid", 64'(o0), 64'(j >= 2 && j < 10));
    end
    chk("ft_d0", 64'(d0), 64'd8);
    // reset while results are buffered and one is in flight
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b0;
    rem0 = 2; rem1 = 2;
    for (int j = 0; j < 4; j++) cycle();
    chk("mid_pre_out0", 64'(out0_valid), 64'd1);
    chk("mid_pre_out1", 64'(out1_valid), 64'd1);
    reset = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    chk("mid_rst_in0_ready", 64'(in0_ready), 64'd0);
    chk("mid_rst_in1_ready", 64'(in1_ready), 64'd0);
    tick();
    reset = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    q0.delete(); q1.delete(); d0 = 0; d1 = 0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    chk("mid_out0_valid", 64'(out0_valid), 64'd0);
    chk("mid_out1_valid", 64'(out1_valid), 64'd0);
    chk("mid_out0_data", out0_data, 64'd0);
    rem0 = 1; rem1 = 1;
    cycle();
    chk("mid_first_g0", 64'(g0), 64'd1);
    chk("mid_first_g1", 64'(g1), 64'd0);
    for (int j = 0; j < 5; j++) cycle();
    chk("mid_d0", 64'(d0), 64'd1);
    chk("mid_d1", 64'(d1), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
